buf_load_sequencer: RTL and testbench

Sequences a buffer-load (MUBUF-style, dword granularity) for one wave lane. It takes a buffer resource descriptor plus index/offset, computes byte addresses, bounds-checks against num_records and issues 64-bit SRAM reads with one outstanding request at a time. It unpacks the returned dwords into consecutive VGPR writes. It sits between the issue stage and the SRAM port and owns the VGPR write port for the duration of the load.

---
 rtl/buf_load_sequencer_pkg.sv | 40 ++++
 rtl/buf_load_sequencer_addr_calc.sv | 30 +++
 rtl/buf_load_sequencer.sv | 166 ++++++++++++++++
 tb/tb_buf_load_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_load_sequencer_pkg.sv
// Shared types and constants for the buffer-load sequencer.
package buf_load_sequencer_pkg;

    localparam int VGPR_ADDR_WIDTH = 8;
    localparam int BUF_MAX_DW      = 4;

    typedef struct packed {
        logic [47:0] base_addr;
        logic [15:0] stride;
        logic [31:0] num_records;
    } buf_resource_t;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } buf_seq_state_t;

    typedef struct packed {
        buf_resource_t                rsrc;
        logic [31:0]                  index;
        logic [31:0]                  offset;
        logic [2:0]                   num_dw;
        logic [VGPR_ADDR_WIDTH-1:0]   vdst;
    } buf_load_req_t;

    // Zero means a single dword; anything beyond the limit is clamped.
    function automatic logic [2:0] clamp_num_dw(input logic [2:0] n, input int max_dw);
        if (n == 3'd0)
            return 3'd1;
        else if (int'(n) > max_dw)
            return 3'(max_dw);
        else
            return n;
    endfunction

endpackage

// File: rtl/buf_load_sequencer_addr_calc.sv
// Combinational base-address and per-dword out-of-bounds mask for a buffer load.
module buf_addr_calc
    import buf_load_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_DW     = BUF_MAX_DW
) (
    input  buf_resource_t          rsrc,
    input  logic [31:0]            index,
    input  logic [31:0]            offset,
    output logic [ADDR_WIDTH-1:0]  base,
    output logic [MAX_DW-1:0]      oob_mask
);

    logic [47:0] sum_full;
    logic        record_oob;

    assign sum_full   = rsrc.base_addr + 48'(index) * 48'(rsrc.stride) + 48'(offset);
    assign base       = sum_full[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(3);
    assign record_oob = (index >= rsrc.num_records);

    // Strided buffers bound by record; raw buffers (stride 0) bound each dword's byte offset.
    generate
        for (genvar gi = 0; gi < MAX_DW; gi++) begin : g_oob
            assign oob_mask[gi] = (rsrc.stride != 16'd0) ? record_oob :
                (({1'b0, offset} + 33'(4 * gi)) >= {1'b0, rsrc.num_records});
        end
    endgenerate

endmodule

// File: rtl/buf_load_sequencer.sv
// Buffer-load sequencer: address/bounds check, one-outstanding 64-bit SRAM reads, VGPR unpack.
// Optional BUF_LOAD_SEQ_OOB_FLAG_EN adds the oob_flag output reporting any zero-filled dword.
module buf_load_sequencer
    import buf_load_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_DW     = BUF_MAX_DW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  buf_resource_t               req_rsrc,
    input  logic [31:0]                 req_index,
    input  logic [31:0]                 req_offset,
    input  logic [2:0]                  req_num_dw,
    input  logic [VGPR_ADDR_WIDTH-1:0]  req_vdst,
    output logic                        sram_req_valid,
    input  logic                        sram_req_ready,
    output logic [ADDR_WIDTH-1:0]       sram_addr,
    input  logic                        sram_rsp_valid,
    input  logic [DATA_WIDTH-1:0]       sram_rsp_data,
    output logic                        vgpr_wr_en,
    output logic [VGPR_ADDR_WIDTH-1:0]  vgpr_wr_addr,
    output logic [31:0]                 vgpr_wr_data,
    output logic                        done
`ifdef BUF_LOAD_SEQ_OOB_FLAG_EN
    ,
    output logic                        oob_flag
`endif
);

    localparam int CNT_W = $clog2(MAX_DW + 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ~ADDR_WIDTH'(7);

    buf_seq_state_t         state;
    buf_load_req_t          req_reg;
    logic [CNT_W-1:0]       dw_idx;
    logic [CNT_W-1:0]       nxt_idx;
    logic [31:0]            beat_hi_reg;

    logic [ADDR_WIDTH-1:0]  base;
    logic [MAX_DW-1:0]      oob_mask;
    logic [2**CNT_W-1:0]    oob_ext;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [ADDR_WIDTH-1:0]  nxt_addr;
    logic                   last_dw;

    buf_addr_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_DW     (MAX_DW)
    ) u_addr_calc (
        .rsrc     (req_reg.rsrc),
        .index    (req_reg.index),
        .offset   (req_reg.offset),
        .base     (base),
        .oob_mask (oob_mask)
    );

    // Padding above MAX_DW is never reached; it only keeps the index in range.
    assign oob_ext  = {{(2**CNT_W - MAX_DW){1'b1}}, oob_mask};
    assign nxt_idx  = dw_idx + CNT_W'(1);
    assign cur_addr = base + ADDR_WIDTH'({dw_idx, 2'b00});
    assign nxt_addr = base + ADDR_WIDTH'({nxt_idx, 2'b00});
    assign last_dw  = (nxt_idx == CNT_W'(req_reg.num_dw));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            sram_req_valid <= 1'b0;
            sram_addr      <= '0;
            vgpr_wr_en     <= 1'b0;
            vgpr_wr_addr   <= '0;
            vgpr_wr_data   <= '0;
            done           <= 1'b0;
            req_reg        <= '0;
            dw_idx         <= '0;
            beat_hi_reg    <= '0;
`ifdef BUF_LOAD_SEQ_OOB_FLAG_EN
            oob_flag       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_reg.rsrc   <= req_rsrc;
                        req_reg.index  <= req_index;
                        req_reg.offset <= req_offset;
                        req_reg.num_dw <= clamp_num_dw(req_num_dw, MAX_DW);
                        req_reg.vdst   <= req_vdst;
                        dw_idx         <= '0;
                        req_ready      <= 1'b0;
                        state          <= CALC;
`ifdef BUF_LOAD_SEQ_OOB_FLAG_EN
                        oob_flag       <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    if (oob_ext[dw_idx]) begin
                        vgpr_wr_en   <= 1'b1;
                        vgpr_wr_addr <= req_reg.vdst;
                        vgpr_wr_data <= '0;
                        state        <= WRITE;
`ifdef BUF_LOAD_SEQ_OOB_FLAG_EN
                        oob_flag     <= 1'b1;
`endif
                    end else begin
                        sram_req_valid <= 1'b1;
                        sram_addr      <= cur_addr & BEAT_MASK;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sram_req_ready) begin
                        sram_req_valid <= 1'b0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (sram_rsp_valid) begin
                        beat_hi_reg  <= sram_rsp_data[63:32];
                        vgpr_wr_en   <= 1'b1;
                        vgpr_wr_addr <= req_reg.vdst + VGPR_ADDR_WIDTH'(dw_idx);
                        vgpr_wr_data <= cur_addr[2] ? sram_rsp_data[63:32] : sram_rsp_data[31:0];
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    dw_idx <= nxt_idx;
                    if (last_dw) begin
                        vgpr_wr_en <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else if (oob_ext[nxt_idx]) begin
                        vgpr_wr_addr <= req_reg.vdst + VGPR_ADDR_WIDTH'(nxt_idx);
                        vgpr_wr_data <= '0;
`ifdef BUF_LOAD_SEQ_OOB_FLAG_EN
                        oob_flag     <= 1'b1;
`endif
                    end else if (!cur_addr[2]) begin
                        // Next dword is the upper half of the beat already held.
                        vgpr_wr_addr <= req_reg.vdst + VGPR_ADDR_WIDTH'(nxt_idx);
                        vgpr_wr_data <= beat_hi_reg;
                    end else begin
                        vgpr_wr_en     <= 1'b0;
                        sram_req_valid <= 1'b1;
                        sram_addr      <= nxt_addr & BEAT_MASK;
                        state          <= ISSUE;
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buf_load_sequencer.sv
// Randomized self-checking bench for buf_load_sequencer against a dword-level reference model.
module tb_buf_load_sequencer;
    import buf_load_sequencer_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        req_valid;
    logic                        req_ready;
    buf_resource_t               req_rsrc;
    logic [31:0]                 req_index;
    logic [31:0]                 req_offset;
    logic [2:0]                  req_num_dw;
    logic [VGPR_ADDR_WIDTH-1:0]  req_vdst;
    logic                        sram_req_valid;
    logic                        sram_req_ready;
    logic [31:0]                 sram_addr;
    logic                        sram_rsp_valid;
    logic [63:0]                 sram_rsp_data;
    logic                        vgpr_wr_en;
    logic [VGPR_ADDR_WIDTH-1:0]  vgpr_wr_addr;
    logic [31:0]                 vgpr_wr_data;
    logic                        done;
`ifdef BUF_LOAD_SEQ_OOB_FLAG_EN
    logic                        oob_flag;
    logic                        last_oob;
`endif

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int rsp_cnt = 0;
    int ready_delay = 0;
    int rsp_delay = 0;
    int txn_no = 0;
    bit busy = 0;
    bit prev_pend = 0;
    logic [31:0] held_addr = '0;

    logic [39:0] wr_log[$];
    logic [31:0] rd_log[$];
    logic [31:0] hs_q[$];
    logic [39:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    logic        exp_oob;

    buf_load_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_rsrc       (req_rsrc),
        .req_index      (req_index),
        .req_offset     (req_offset),
        .req_num_dw     (req_num_dw),
        .req_vdst       (req_vdst),
        .sram_req_valid (sram_req_valid),
        .sram_req_ready (sram_req_ready),
        .sram_addr      (sram_addr),
        .sram_rsp_valid (sram_rsp_valid),
        .sram_rsp_data  (sram_rsp_data),
        .vgpr_wr_en     (vgpr_wr_en),
        .vgpr_wr_addr   (vgpr_wr_addr),
        .vgpr_wr_data   (vgpr_wr_data),
        .done           (done)
`ifdef BUF_LOAD_SEQ_OOB_FLAG_EN
        ,
        .oob_flag       (oob_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_dw(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [63:0] mem_beat(input logic [31:0] a);
        logic [31:0] line;
        line = {a[31:3], 3'b000};
        return {mem_dw(line + 32'd4), mem_dw(line)};
    endfunction

    // Reference: walk the dwords, decide bounds and whether each needs a fresh 8-byte line.
    task automatic build_expect();
        int          n;
        logic [47:0] full;
        logic [31:0] base, a, prev_a;
        logic        oob, prev_oob;
        n = (req_num_dw == 0) ? 1 : ((req_num_dw > 4) ? 4 : int'(req_num_dw));
        full = req_rsrc.base_addr + 48'(req_index) * 48'(req_rsrc.stride) + 48'(req_offset);
        base = full[31:0] & 32'hFFFF_FFFC;
        exp_wr.delete();
        exp_rd.delete();
        exp_oob = 1'b0;
        prev_a = '0;
        prev_oob = 1'b1;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            if (req_rsrc.stride != 0)
                oob = (req_index >= req_rsrc.num_records);
            else
                oob = ({1'b0, req_offset} + 33'(4 * i)) >= {1'b0, req_rsrc.num_records};
            exp_wr.push_back({req_vdst + 8'(i), oob ? 32'd0 : mem_dw(a)});
            if (!oob && !(i > 0 && !prev_oob && a[31:3] == prev_a[31:3]))
                exp_rd.push_back({a[31:3], 3'b000});
            exp_oob |= oob;
            prev_a = a;
            prev_oob = oob;
        end
    endtask

    // SRAM model: configurable accept delay and response latency.
    initial begin
        int          wcnt, pcnt;
        bit          pend;
        logic [31:0] pend_addr;
        wcnt = 0; pcnt = 0; pend = 0; pend_addr = '0;
        sram_req_ready = 1'b0;
        sram_rsp_valid = 1'b0;
        sram_rsp_data  = '0;
        forever begin
            @(posedge clk); #1;
            sram_rsp_valid = 1'b0;
            if (hs_q.size() > 0) begin
                pend_addr = hs_q.pop_front();
                pend = 1;
                pcnt = rsp_delay;
            end
            if (pend) begin
                if (pcnt == 0) begin
                    sram_rsp_valid = 1'b1;
                    sram_rsp_data  = mem_beat(pend_addr);
                    pend = 0;
                end else begin
                    pcnt--;
                end
            end
            if (!sram_req_valid) begin
                wcnt = 0;
                sram_req_ready = 1'b0;
            end else begin
                sram_req_ready = (wcnt >= ready_delay);
                wcnt++;
            end
        end
    end

    // Monitor: logs writes/reads and checks handshake invariants every cycle.
    always @(negedge clk) begin
        if (rst) begin
            busy = 0;
            prev_pend = 0;
        end else begin
            if (vgpr_wr_en)
                wr_log.push_back({vgpr_wr_addr, vgpr_wr_data});
            if (hs_cnt != rsp_cnt)
                chk("wr_before_rsp", {63'd0, vgpr_wr_en}, 64'd0);
            if (sram_req_valid && prev_pend)
                chk("addr_hold", {32'd0, sram_addr}, {32'd0, held_addr});
            prev_pend = sram_req_valid && !sram_req_ready;
            held_addr = sram_addr;
            if (sram_req_valid && sram_req_ready) begin
                rd_log.push_back(sram_addr);
                hs_q.push_back(sram_addr);
                hs_cnt++;
            end
            if (sram_rsp_valid)
                rsp_cnt++;
            if (busy)
                chk("ready_busy", {63'd0, req_ready}, 64'd0);
            if (done) begin
                done_cnt++;
                busy = 0;
`ifdef BUF_LOAD_SEQ_OOB_FLAG_EN
                last_oob = oob_flag;
`endif
            end
            if (req_valid && req_ready)
                busy = 1;
        end
    end

    task automatic start_req();
        bit ok;
        req_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        chk("accept", {63'd0, ok}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input string name);
        int d0;
        bit ok;
        int nw, nr;
        build_expect();
        wr_log.delete();
        rd_log.delete();
        d0 = done_cnt;
        start_req();
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #2;
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
        chk({name, "_done_seen"}, {63'd0, ok}, 64'd1);
        repeat (3) @(posedge clk);
        #2;
        chk({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_wr_count"}, 64'(wr_log.size()), 64'(exp_wr.size()));
        nw = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
        for (int i = 0; i < nw; i++)
            chk({name, "_wr"}, {24'd0, wr_log[i]}, {24'd0, exp_wr[i]});
        chk({name, "_rd_count"}, 64'(rd_log.size()), 64'(exp_rd.size()));
        nr = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
        for (int i = 0; i < nr; i++)
            chk({name, "_rd_addr"}, {32'd0, rd_log[i]}, {32'd0, exp_rd[i]});
`ifdef BUF_LOAD_SEQ_OOB_FLAG_EN
        chk({name, "_oob_flag"}, {63'd0, last_oob}, {63'd0, exp_oob});
`endif
        $display("txn %0d %s: dw=%0d writes=%0d reads=%0d oob=%0d", txn_no, name,
                 req_num_dw, wr_log.size(), rd_log.size(), exp_oob);
        txn_no++;
    endtask

    task automatic set_req(input logic [47:0] b, input logic [15:0] s, input logic [31:0] nrec,
                           input logic [31:0] idx, input logic [31:0] off,
                           input logic [2:0] nd, input logic [7:0] vd);
        req_rsrc.base_addr   = b;
        req_rsrc.stride      = s;
        req_rsrc.num_records = nrec;
        req_index  = idx;
        req_offset = off;
        req_num_dw = nd;
        req_vdst   = vd;
    endtask

    initial begin
        int r0;
        bit ok;
        rst = 1'b1;
        req_valid = 1'b0;
        set_req(48'h0, 16'h0, 32'h0, 32'h0, 32'h0, 3'd0, 8'd0);
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_sram_valid", {63'd0, sram_req_valid}, 64'd0);
        chk("rst_wr_en", {63'd0, vgpr_wr_en}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_sram_addr", {32'd0, sram_addr}, 64'd0);
        chk("rst_wr_addr_data", {24'd0, vgpr_wr_addr, vgpr_wr_data}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        set_req(48'h1000, 16'd16, 32'd8, 32'd2, 32'd4, 3'd2, 8'd10);
        run_txn("unaligned2");
        set_req(48'h1000, 16'd16, 32'd8, 32'd2, 32'd0, 3'd2, 8'd10);
        run_txn("aligned2");
        set_req(48'h1000, 16'd16, 32'd8, 32'd8, 32'd0, 3'd4, 8'd20);
        run_txn("record_oob");
        set_req(48'h2000, 16'd0, 32'd12, 32'd5, 32'd8, 3'd3, 8'd30);
        run_txn("raw_partial_oob");
        ready_delay = 5; rsp_delay = 3;
        set_req(48'h1000, 16'd16, 32'd8, 32'd2, 32'd0, 3'd2, 8'd40);
        run_txn("slow_sram");
        set_req(48'h3000, 16'd4, 32'd100, 32'd1, 32'd0, 3'd0, 8'd255);
        run_txn("num_dw_zero");
        set_req(48'h3000, 16'd4, 32'd100, 32'd1, 32'd4, 3'd7, 8'd254);
        run_txn("num_dw_clamp");

        // Reset while waiting on the SRAM; the delayed response then lands in IDLE.
        ready_delay = 0; rsp_delay = 6;
        set_req(48'h1000, 16'd16, 32'd8, 32'd2, 32'd0, 3'd2, 8'd50);
        r0 = hs_cnt;
        start_req();
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #2;
            if (hs_cnt != r0) begin
                ok = 1;
                break;
            end
        end
        chk("stale_issue_seen", {63'd0, ok}, 64'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wr_log.delete();
        r0 = rsp_cnt;
        repeat (10) @(posedge clk);
        #2;
        chk("stale_rsp_seen", 64'(rsp_cnt - r0), 64'd1);
        chk("stale_no_write", 64'(wr_log.size()), 64'd0);
        chk("stale_req_ready", {63'd0, req_ready}, 64'd1);
        $display("txn %0d reset_in_wait: writes=%0d req_ready=%0d", txn_no, wr_log.size(), req_ready);
        txn_no++;
        rsp_delay = 0;
        run_txn("after_reset");

        for (int t = 0; t < 40; t++) begin
            logic [15:0] s;
            ready_delay = $urandom_range(0, 3);
            rsp_delay   = $urandom_range(0, 3);
            s = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 64));
            set_req({16'($urandom), $urandom}, s, 32'($urandom_range(0, 40)),
                    32'($urandom_range(0, 12)), 32'($urandom_range(0, 48)),
                    3'($urandom_range(0, 7)), 8'($urandom));
            run_txn("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
